// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
//
// Two-stage pipelined branch-condition and target unit. It sits between
// register-read and PC-select.
//   Stage 1 (s1_*_q)  : captures the request (mode, operands, pc, offset).
//   Stage 2 (out_*_q) : holds the evaluated condition, the target, the operand
//                       XOR and the illegal-mode flag.
// A saturating counter records how many taken branches were delivered to the
// consumer.
//
// Ports
//   clk, rst      : clock (rising edge) and synchronous active-high reset
//   flush         : kills both pipeline stages at the next edge
//   in_valid/in_ready, in_mode, in_x, in_y, in_pc, in_offset : request side
//   out_valid/out_ready, out_taken, out_target, out_diff, out_err : result side
//   taken_count   : saturating count of delivered taken branches
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer must keep valid and its payload stable until that edge. The
// result payload on out_* is held stable while out_valid && !out_ready.
//
// Mode codes: 000 BEQ, 001 BNE, 010 BLT (signed), 011 BGE (signed),
//             100 BLTU, 101 BGEU, 110/111 illegal (not taken, err set).
// -----------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int WIDTH     = 16,
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_mode,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic [OFF_WIDTH-1:0] in_offset,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_taken,
  output logic [PC_WIDTH-1:0]  out_target,
  output logic [WIDTH-1:0]     out_diff,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] taken_count
);

  localparam logic [2:0] MODE_BEQ  = 3'b000;
  localparam logic [2:0] MODE_BNE  = 3'b001;
  localparam logic [2:0] MODE_BLT  = 3'b010;
  localparam logic [2:0] MODE_BGE  = 3'b011;
  localparam logic [2:0] MODE_BLTU = 3'b100;
  localparam logic [2:0] MODE_BGEU = 3'b101;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Stage 1 registers
  logic                 s1_valid_q;
  logic [2:0]           s1_mode_q;
  logic [WIDTH-1:0]     s1_x_q;
  logic [WIDTH-1:0]     s1_y_q;
  logic [PC_WIDTH-1:0]  s1_pc_q;
  logic [OFF_WIDTH-1:0] s1_off_q;

  // Stage 2 / output registers
  logic                 out_valid_q;
  logic                 out_taken_q;
  logic [PC_WIDTH-1:0]  out_target_q;
  logic [WIDTH-1:0]     out_diff_q;
  logic                 out_err_q;
  logic [CNT_WIDTH-1:0] taken_count_q;

  // Stage 2 next-state values
  logic                 taken_d;
  logic                 err_d;
  logic [PC_WIDTH-1:0]  target_d;
  logic [WIDTH-1:0]     diff_d;

  logic                 eq;
  logic                 lt_s;
  logic                 lt_u;
  logic [PC_WIDTH-1:0]  pc_plus1;
  logic [PC_WIDTH-1:0]  off_sext;

  logic                 accept;
  logic                 out_fire;
  logic                 load_out;

  // in_ready also depends on out_ready so a full pipe still streams at one
  // request per cycle when the consumer is draining.
  assign in_ready = !rst && !flush && (!s1_valid_q || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  // Flush suppresses the reload, so a result delivered on a flush cycle is
  // not replaced by the (killed) stage-1 entry.
  assign load_out = s1_valid_q && (!out_valid_q || out_ready) && !flush;

  // Compare and target arithmetic, all on stage-1 registers.
  assign diff_d   = s1_x_q ^ s1_y_q;
  assign eq       = (s1_x_q == s1_y_q);
  assign lt_s     = ($signed(s1_x_q) < $signed(s1_y_q));
  assign lt_u     = (s1_x_q < s1_y_q);
  assign pc_plus1 = s1_pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign off_sext = {{(PC_WIDTH-OFF_WIDTH){s1_off_q[OFF_WIDTH-1]}}, s1_off_q};

  always_comb begin
    taken_d = 1'b0;
    err_d   = 1'b0;
    case (s1_mode_q)
      MODE_BEQ:  taken_d = eq;
      MODE_BNE:  taken_d = !eq;
      MODE_BLT:  taken_d = lt_s;
      MODE_BGE:  taken_d = !lt_s;
      MODE_BLTU: taken_d = lt_u;
      MODE_BGEU: taken_d = !lt_u;
      default:   err_d   = 1'b1;
    endcase
    // Sum wraps modulo 2^PC_WIDTH by construction.
    target_d = taken_d ? (pc_plus1 + off_sext) : pc_plus1;
  end

  // Stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_pc_q    <= '0;
      s1_off_q   <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_mode_q  <= in_mode;
      s1_x_q     <= in_x;
      s1_y_q     <= in_y;
      s1_pc_q    <= in_pc;
      s1_off_q   <= in_offset;
    end else if (load_out) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 / output
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_taken_q  <= 1'b0;
      out_target_q <= '0;
      out_diff_q   <= '0;
      out_err_q    <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
    end else if (load_out) begin
      out_valid_q  <= 1'b1;
      out_taken_q  <= taken_d;
      out_target_q <= target_d;
      out_diff_q   <= diff_d;
      out_err_q    <= err_d;
    end else if (out_fire) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Taken counter: counts deliveries, including one made on a flush cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_count_q <= '0;
    end else if (out_fire && out_taken_q && (taken_count_q != CNT_MAX)) begin
      taken_count_q <= taken_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid   = out_valid_q;
  assign out_taken   = out_taken_q;
  assign out_target  = out_target_q;
  assign out_diff    = out_diff_q;
  assign out_err     = out_err_q;
  assign taken_count = taken_count_q;

endmodule
